layer4_buf_ctrl: RTL and testbench



---
 rtl/layer4_buf_ctrl.sv | 157 +++++++++++++++
 tb/tb_layer4_buf_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer4_buf_ctrl.sv
// Access controller / arbiter for the dual-port layer-4 buffer: wr+rd1 share port A, rd0 owns port B.
// Optional rd0 stall statistics are enabled by defining LAYER4_BUF_CTRL_STATS_EN.
module layer4_buf_ctrl #(
  parameter int DEPTH        = 144,
  parameter int AW           = 8,
  parameter int DW           = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CK,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd0_req,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_gnt,
  output logic          rd0_valid,
  output logic [DW-1:0] rd0_data,
  input  logic          rd1_req,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_gnt,
  output logic          rd1_valid,
  output logic [DW-1:0] rd1_data,
  output logic          full,
  output logic          err,
  output logic [15:0]   stall_cnt,
  output logic          sram_oea,
  output logic          sram_oeb,
  output logic          sram_wean,
  output logic          sram_webn,
  output logic [AW-1:0] sram_a,
  output logic [AW-1:0] sram_b,
  output logic [DW-1:0] sram_dia,
  output logic [DW-1:0] sram_dib,
  input  logic [DW-1:0] sram_doa,
  input  logic [DW-1:0] sram_dob
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t           state;
  logic [DEPTH-1:0] bitmap;
  logic [CW-1:0]    fill_cnt;
  logic [SW-1:0]    starve;
  logic             rd0_hit;
  logic [1:0]       rd1_src;

  logic active, force_rd1;
  logic wr_inr, rd0_inr, rd1_inr;
  logic a_wr, a_rd, b_rd, shared, oor;
  logic [AW-1:0] a_addr;

  assign active    = (state != IDLE) && !start && !rst;
  assign force_rd1 = (starve >= SW'(STARVE_LIMIT));
  assign wr_inr    = wr_addr  < AW'(DEPTH);
  assign rd0_inr   = rd0_addr < AW'(DEPTH);
  assign rd1_inr   = rd1_addr < AW'(DEPTH);

  // rd0 waits for written data and never races a write to the same word.
  always_comb begin
    wr_gnt  = active && wr_req && !(rd1_req && force_rd1);
    rd1_gnt = active && rd1_req && (!wr_req || force_rd1);
    rd0_gnt = active && rd0_req &&
              (!rd0_inr || (bitmap[rd0_addr] && !(wr_gnt && wr_addr == rd0_addr)));
    a_wr    = wr_gnt && wr_inr;
    b_rd    = rd0_gnt && rd0_inr;
    shared  = rd1_gnt && rd1_inr && b_rd && (rd1_addr == rd0_addr);
    a_rd    = rd1_gnt && rd1_inr && !shared;
    a_addr  = a_wr ? wr_addr : rd1_addr;
    oor     = (wr_gnt && !wr_inr) || (rd0_gnt && !rd0_inr) || (rd1_gnt && !rd1_inr);
  end

  // An idle port parks on the neighbour of the busy port's address so A and B never match.
  always_comb begin
    sram_wean = !a_wr;
    sram_webn = 1'b1;
    sram_oea  = a_rd;
    sram_oeb  = b_rd;
    sram_dia  = a_wr ? wr_data : '0;
    sram_dib  = '0;
    if (a_wr || a_rd) begin
      sram_a = a_addr;
      sram_b = b_rd ? rd0_addr : {a_addr[AW-1:1], ~a_addr[0]};
    end else if (b_rd) begin
      sram_a = {rd0_addr[AW-1:1], ~rd0_addr[0]};
      sram_b = rd0_addr;
    end else begin
      sram_a = '0;
      sram_b = AW'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (rst) begin
      state     <= IDLE;
      bitmap    <= '0;
      fill_cnt  <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      starve    <= '0;
      rd0_valid <= 1'b0;
      rd0_hit   <= 1'b0;
      rd1_valid <= 1'b0;
      rd1_src   <= 2'b00;
    end else begin
      rd0_valid <= rd0_gnt;
      rd0_hit   <= b_rd;
      rd1_valid <= rd1_gnt;
      rd1_src   <= {shared, a_rd};
      if (start) begin
        state    <= FILL;
        bitmap   <= '0;
        fill_cnt <= '0;
        full     <= 1'b0;
        err      <= 1'b0;
        starve   <= '0;
      end else begin
        // Only first writes to a word advance the fill count.
        if (a_wr && !bitmap[wr_addr]) begin
          bitmap[wr_addr] <= 1'b1;
          fill_cnt        <= fill_cnt + 1'b1;
          if (state == FILL && fill_cnt == CW'(DEPTH - 1)) begin
            state <= FULL;
            full  <= 1'b1;
          end
        end
        if (oor) err <= 1'b1;
        if (rd1_gnt)
          starve <= '0;
        else if (active && rd1_req && !force_rd1)
          starve <= starve + 1'b1;
      end
    end
  end

  assign rd0_data = rd0_hit ? sram_dob : '0;
  assign rd1_data = rd1_src[0] ? sram_doa : (rd1_src[1] ? sram_dob : '0);

`ifdef LAYER4_BUF_CTRL_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge CK) begin
    if (rst || start)
      stall_q <= '0;
    else if ((state == FILL || state == FULL) && rd0_req && !rd0_gnt && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_layer4_buf_ctrl.sv
// Bench for layer4_buf_ctrl: behavioural dual-port SRAM, reference memory and read scoreboards.
module tb_layer4_buf_ctrl;
  localparam int DEPTH = 144;
  localparam int AW    = 8;
  localparam int DW    = 128;
`ifdef LAYER4_BUF_CTRL_STATS_EN
  localparam int STALL_EXP = 7;
`else
  localparam int STALL_EXP = 0;
`endif

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic rst, start, wr_req, rd0_req, rd1_req;
  logic [AW-1:0] wr_addr, rd0_addr, rd1_addr;
  logic [DW-1:0] wr_data;
  logic wr_gnt, rd0_gnt, rd0_valid, rd1_gnt, rd1_valid, full, err;
  logic [DW-1:0] rd0_data, rd1_data;
  logic [15:0] stall_cnt;
  logic sram_oea, sram_oeb, sram_wean, sram_webn;
  logic [AW-1:0] sram_a, sram_b;
  logic [DW-1:0] sram_dia, sram_dib, sram_doa, sram_dob;

  layer4_buf_ctrl dut (
    .CK(CK), .rst(rst), .start(start),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .full(full), .err(err), .stall_cnt(stall_cnt),
    .sram_oea(sram_oea), .sram_oeb(sram_oeb), .sram_wean(sram_wean), .sram_webn(sram_webn),
    .sram_a(sram_a), .sram_b(sram_b), .sram_dia(sram_dia), .sram_dib(sram_dib),
    .sram_doa(sram_doa), .sram_dob(sram_dob)
  );

  logic [DW-1:0] mem [0:255];
  always @(posedge CK) begin
    if (!sram_wean) mem[sram_a] <= sram_dia;
    if (!sram_webn) mem[sram_b] <= sram_dib;
    if (sram_oea) sram_doa <= mem[sram_a];
    if (sram_oeb) sram_dob <= mem[sram_b];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int at; } exp_t;
  exp_t q0[$], q1[$];
  exp_t m0, m1;
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (a < AW'(DEPTH)) ? ref_mem[a] : '0;
  endfunction

  // Called #1 after inputs settle: record what each grant must return one cycle later.
  task automatic note_grants();
    if (rd0_gnt) q0.push_back('{exp_rd(rd0_addr), cyc + 1});
    if (rd1_gnt) q1.push_back('{exp_rd(rd1_addr), cyc + 1});
    if (wr_gnt && wr_addr < AW'(DEPTH)) ref_mem[wr_addr] = wr_data;
  endtask

  task automatic clr_req();
    start = 0; wr_req = 0; rd0_req = 0; rd1_req = 0;
  endtask

  always @(negedge CK) begin
    #2;
    total++;
    if (sram_a === sram_b) begin
      bad++; $display("FAIL addr_clash cyc=%0d a=%0d b=%0d (must differ)", cyc, sram_a, sram_b);
    end
    if (rd0_valid) begin
      total++;
      if (q0.size() == 0) begin
        bad++; $display("FAIL rd0_spurious cyc=%0d data=%h", cyc, rd0_data);
      end else begin
        m0 = q0.pop_front();
        if (rd0_data !== m0.d || cyc != m0.at) begin
          bad++; $display("FAIL rd0_data cyc=%0d got=%h want=%h due=%0d", cyc, rd0_data, m0.d, m0.at);
        end
      end
    end else begin
      if (q0.size() > 0 && q0[0].at <= cyc) begin
        total++; bad++; $display("FAIL rd0_missing cyc=%0d want valid due=%0d", cyc, q0[0].at);
        m0 = q0.pop_front();
      end
      if (rd0_data !== '0) begin
        total++; bad++; $display("FAIL rd0_idle_data cyc=%0d got=%h want=0", cyc, rd0_data);
      end
    end
    if (rd1_valid) begin
      total++;
      if (q1.size() == 0) begin
        bad++; $display("FAIL rd1_spurious cyc=%0d data=%h", cyc, rd1_data);
      end else begin
        m1 = q1.pop_front();
        if (rd1_data !== m1.d || cyc != m1.at) begin
          bad++; $display("FAIL rd1_data cyc=%0d got=%h want=%h due=%0d", cyc, rd1_data, m1.d, m1.at);
        end
      end
    end else begin
      if (q1.size() > 0 && q1[0].at <= cyc) begin
        total++; bad++; $display("FAIL rd1_missing cyc=%0d want valid due=%0d", cyc, q1[0].at);
        m1 = q1.pop_front();
      end
      if (rd1_data !== '0) begin
        total++; bad++; $display("FAIL rd1_idle_data cyc=%0d got=%h want=0", cyc, rd1_data);
      end
    end
  end

  task automatic test_reset();
    rst = 1; wr_req = 1; rd0_req = 1; rd1_req = 1;
    wr_addr = 3; rd0_addr = 3; rd1_addr = 4; wr_data = '1;
    #1; total++;
    if ({wr_gnt, rd0_gnt, rd1_gnt} !== 3'b000) begin
      bad++; $display("FAIL rst_gnt got=%b want=000", {wr_gnt, rd0_gnt, rd1_gnt});
    end
    @(negedge CK); clr_req(); @(negedge CK);
    #1; total++;
    if ({rd0_valid, rd1_valid, full, err, sram_oea, sram_oeb, sram_wean, sram_webn} !== 8'b0000_0011) begin
      bad++; $display("FAIL rst_flags got=%b want=00000011",
                      {rd0_valid, rd1_valid, full, err, sram_oea, sram_oeb, sram_wean, sram_webn});
    end
    total++;
    if (sram_a !== 8'd0 || sram_b !== 8'd1) begin
      bad++; $display("FAIL rst_addr got a=%0d b=%0d want a=0 b=1", sram_a, sram_b);
    end
    total++;
    if (sram_dia !== '0 || sram_dib !== '0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_data got dia=%h dib=%h stall=%0d want 0", sram_dia, sram_dib, stall_cnt);
    end
    rst = 0; @(negedge CK);
    wr_req = 1; rd0_req = 1; rd1_req = 1;
    #1; total++;
    if ({wr_gnt, rd0_gnt, rd1_gnt} !== 3'b000) begin
      bad++; $display("FAIL idle_gnt got=%b want=000", {wr_gnt, rd0_gnt, rd1_gnt});
    end
    @(negedge CK); clr_req();
  endtask

  task automatic test_fill();
    start = 1; wr_req = 1; wr_addr = 0; wr_data = 0;
    #1; total++;
    if (wr_gnt !== 1'b0) begin bad++; $display("FAIL start_gnt got=%b want=0", wr_gnt); end
    @(negedge CK); start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_req = 1; wr_addr = AW'(i); wr_data = DW'(i);
      #1; total++;
      if (wr_gnt !== 1'b1 || sram_wean !== 1'b0 || sram_a !== AW'(i) || sram_dia !== DW'(i) || full !== 1'b0) begin
        bad++; $display("FAIL fill_wr i=%0d gnt=%b wean=%b a=%0d full=%b want gnt=1 wean=0 a=%0d full=0",
                        i, wr_gnt, sram_wean, sram_a, full, i);
      end
      note_grants(); @(negedge CK);
    end
    wr_addr = 5; wr_data = 128'h5555;
    #1; total++;
    if (full !== 1'b1 || wr_gnt !== 1'b1) begin
      bad++; $display("FAIL full_rise full=%b gnt=%b want 1 1", full, wr_gnt);
    end
    note_grants(); @(negedge CK); clr_req();
    rd1_req = 1; rd1_addr = 5; rd0_req = 1; rd0_addr = 143;
    #1; total++;
    if (full !== 1'b1 || rd0_gnt !== 1'b1 || rd1_gnt !== 1'b1 || sram_oea !== 1'b1 || sram_oeb !== 1'b1) begin
      bad++; $display("FAIL full_reads full=%b g0=%b g1=%b oea=%b oeb=%b want all 1",
                      full, rd0_gnt, rd1_gnt, sram_oea, sram_oeb);
    end
    note_grants(); @(negedge CK); clr_req();
    rd0_req = 1; rd0_addr = 0;
    #1; note_grants(); @(negedge CK); clr_req();
    @(negedge CK);
  endtask

  task automatic test_stall();
    start = 1; @(negedge CK); start = 0;
    for (int i = 0; i < 6; i++) begin
      rd0_req = 1; rd0_addr = 10;
      #1; total++;
      if (rd0_gnt !== 1'b0) begin bad++; $display("FAIL unwritten_rd0 i=%0d gnt=%b want=0", i, rd0_gnt); end
      @(negedge CK);
    end
    wr_req = 1; wr_addr = 10; wr_data = {4{32'hC0FFEE01}};
    #1; total++;
    if (wr_gnt !== 1'b1 || rd0_gnt !== 1'b0) begin
      bad++; $display("FAIL raw_same got wr=%b rd0=%b want wr=1 rd0=0", wr_gnt, rd0_gnt);
    end
    note_grants(); @(negedge CK); wr_req = 0;
    #1; total++;
    if (rd0_gnt !== 1'b1) begin bad++; $display("FAIL raw_retry gnt=%b want=1", rd0_gnt); end
    total++;
    if (stall_cnt !== 16'(STALL_EXP)) begin
      bad++; $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, STALL_EXP);
    end
    note_grants(); @(negedge CK); clr_req(); @(negedge CK);
  endtask

  task automatic test_starve();
    int k;
    logic want;
    k = 0;
    rd1_req = 1; rd1_addr = 10;
    for (int i = 0; i < 10; i++) begin
      wr_req = 1; wr_addr = AW'(30 + k); wr_data = DW'(256 + k);
      want = (i % 5 == 4);
      #1; total++;
      if (rd1_gnt !== want || wr_gnt !== !want) begin
        bad++; $display("FAIL starve i=%0d rd1=%b wr=%b want rd1=%b wr=%b", i, rd1_gnt, wr_gnt, want, !want);
      end
      if (want) begin
        total++;
        if (sram_oea !== 1'b1 || sram_wean !== 1'b1 || sram_a !== 8'd10) begin
          bad++; $display("FAIL starve_port oea=%b wean=%b a=%0d want 1 1 10", sram_oea, sram_wean, sram_a);
        end
      end
      if (wr_gnt) k++;
      note_grants(); @(negedge CK);
    end
    clr_req(); @(negedge CK);
  endtask

  task automatic test_shared();
    wr_req = 1; wr_addr = 20; wr_data = {16{8'hAB}};
    #1; note_grants(); @(negedge CK); clr_req();
    rd0_req = 1; rd0_addr = 20; rd1_req = 1; rd1_addr = 20;
    #1; total++;
    if (rd0_gnt !== 1'b1 || rd1_gnt !== 1'b1) begin
      bad++; $display("FAIL shared_gnt got g0=%b g1=%b want 1 1", rd0_gnt, rd1_gnt);
    end
    total++;
    if (sram_oea !== 1'b0 || sram_wean !== 1'b1 || sram_oeb !== 1'b1 || sram_b !== 8'd20) begin
      bad++; $display("FAIL shared_port oea=%b wean=%b oeb=%b b=%0d want 0 1 1 20",
                      sram_oea, sram_wean, sram_oeb, sram_b);
    end
    note_grants(); @(negedge CK); clr_req(); @(negedge CK);
  endtask

  task automatic test_oor();
    rd1_req = 1; rd1_addr = 150;
    #1; total++;
    if (rd1_gnt !== 1'b1 || sram_oea !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL oor_rd1 gnt=%b oea=%b err=%b want 1 0 0", rd1_gnt, sram_oea, err);
    end
    note_grants(); @(negedge CK); clr_req();
    rd0_req = 1; rd0_addr = 200;
    #1; total++;
    if (rd0_gnt !== 1'b1 || sram_oeb !== 1'b0 || err !== 1'b1) begin
      bad++; $display("FAIL oor_rd0 gnt=%b oeb=%b err=%b want 1 0 1", rd0_gnt, sram_oeb, err);
    end
    note_grants(); @(negedge CK); clr_req();
    wr_req = 1; wr_addr = 160; wr_data = '1;
    #1; total++;
    if (wr_gnt !== 1'b1 || sram_wean !== 1'b1) begin
      bad++; $display("FAIL oor_wr gnt=%b wean=%b want 1 1", wr_gnt, sram_wean);
    end
    note_grants(); @(negedge CK); clr_req();
    for (int i = 0; i < 3; i++) begin
      #1; total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_sticky i=%0d err=%b want=1", i, err); end
      @(negedge CK);
    end
    start = 1; @(negedge CK); start = 0;
    #1; total++;
    if (err !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL start_clear err=%b full=%b want 0 0", err, full);
    end
    @(negedge CK);
  endtask

  task automatic test_reset_mid();
    wr_req = 1; wr_addr = 40; wr_data = 128'h40;
    #1; note_grants(); @(negedge CK); clr_req();
    rst = 1; rd0_req = 1; rd0_addr = 40; rd1_req = 1; rd1_addr = 40;
    #1; total++;
    if (rd0_gnt !== 1'b0 || rd1_gnt !== 1'b0) begin
      bad++; $display("FAIL rst_mid_gnt g0=%b g1=%b want 0 0", rd0_gnt, rd1_gnt);
    end
    @(negedge CK); rst = 0;
    #1; total++;
    if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0 || rd0_gnt !== 1'b0 || rd1_gnt !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after v0=%b v1=%b g0=%b g1=%b want 0", rd0_valid, rd1_valid, rd0_gnt, rd1_gnt);
    end
    @(negedge CK); clr_req(); @(negedge CK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d bench did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; clr_req();
    wr_addr = 0; rd0_addr = 0; rd1_addr = 0; wr_data = '0;
    @(negedge CK);
    test_reset();
    test_fill();
    test_stall();
    test_starve();
    test_shared();
    test_oor();
    test_reset_mid();
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++; $display("FAIL drain q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
